tdm_demux_4ch: RTL and testbench
================================

Name: tdm_demux_4ch

Overview:
- Receive end of the 4:1 channel multiplexer. Accepts a time-division-multiplexed serial stream: one sample per slot, 4 slots per frame, slot 0 marked by frame_sync.
- Rebuilds the 4-channel word and presents it as a registered parallel output with a one-cycle frame_valid strobe.
- Tracks frame alignment and flags sync errors.
- Sits after the mux/serial link and feeds channel-level logic such as LEDs or comparators.

Parameters:
- WIDTH, 1: bits per channel sample. A value of 1 matches the 1-bit mux output Q.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- din  input  WIDTH  serial sample for the current slot
- din_valid  input  1  din holds a sample this cycle; the slot advances only when this is high
- frame_sync  input  1  qualified by din_valid; marks the din sample as slot 0
- channel  output  4*WIDTH  last complete frame; slot k is at channel[k*WIDTH +: WIDTH]
- sel  output  2  slot index expected for the next accepted sample
- frame_valid  output  1  one-cycle pulse when channel updates
- locked  output  1  high while in RUN
- sync_err  output  1  one-cycle pulse on a misplaced frame_sync

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=HUNT, sel=0, shadow registers=0, channel=0.
  - frame_valid=0, locked=0, sync_err=0.
  - Takes effect immediately, including mid-frame. The partial frame is discarded, and channel does not update from it after release.
- Accept: a sample is accepted on a rising edge with din_valid=1. With din_valid=0, all state holds and the pulse outputs go to 0.
- HUNT state:
  - Accepted samples with frame_sync=0 are ignored.
  - An accepted sample with frame_sync=1 stores din into shadow[0], sets sel=1, moves to RUN, and sets locked=1 (visible next cycle).
- RUN state, accepted sample with frame_sync=0:
  - Slots 0-2: shadow[sel] <= din, sel <= sel+1.
  - Slot 3: channel <= {din, shadow[2], shadow[1], shadow[0]}, frame_valid <= 1, sel <= 0 (wraps).
  - Latency: channel and frame_valid are visible the cycle after the slot-3 sample is accepted.
- RUN state, accepted sample with frame_sync=1:
  - sel==0: normal slot-0 capture, no error.
  - sel!=0 (early sync): sync_err <= 1, partial frame dropped, channel unchanged, din stored as slot 0, sel <= 1. Stays in RUN.
- RUN state, sel==0 and accepted sample with frame_sync=0 (missing sync):
  - sync_err <= 1, state -> HUNT, locked <= 0, sel <= 0.
  - The sample is discarded.
- Pulse outputs: frame_valid and sync_err are registered pulses, high for exactly one cycle per event. Both can never be high in the same cycle.
- Gaps: din_valid gaps of any length inside a frame are legal and do not cause an error.
- Output stability: channel holds its value between frame_valid pulses.
- Width rule: sel is a 2-bit counter that wraps 3 -> 0 naturally. No other arithmetic.

Decomposition:
- Shared header tdm_defs.vh holds:
  - NCH=4 and SLOT_W=2.
  - State localparams HUNT=1'b0 and RUN=1'b1.
  - The same header is used by the mux-side framer.
- One sub-module is natural: tdm_slot_counter.
  - Ports: clk, rst_n, inc, load1, clr.
  - Function: 2-bit wrapping counter. Drives sel.
  - Top level keeps the FSM, shadow registers and output registers.

Test Plan:
- After reset, din_valid=1 with frame_sync=1 on the 1st sample and din sequence 1,0,1,0 (i.e. channel 4'h5 serialized slot 0 first) -> locked=1; after the 4th sample, channel=4'h5 and frame_valid is high for exactly one cycle.
- Second frame 0,1,0,1 with sync on its first sample -> channel=4'ha, one frame_valid pulse, sync_err stays 0.
- Frame 4'h5 with din_valid=0 for 3 cycles between slot 1 and slot 2 -> channel=4'h5; frame_valid is asserted only after slot 3.
- After 2 samples of a frame, assert frame_sync with din=0, then send 1,1,1 -> one sync_err pulse; then channel=4'he; locked stays 1.
- While locked, send the slot-0 sample without frame_sync -> one sync_err pulse, locked=0, channel unchanged; the next synced frame 4'h3 relocks and outputs 4'h3.
- Pulse rst_n low after slot 2 of a frame -> channel=0 and all outputs 0 immediately; after release, the stray slot-3 sample is ignored in HUNT and no frame_valid is produced.

Source files
------------

// File: rtl/tdm_demux_4ch_pkg.sv
// Shared definitions for the 4-channel TDM demultiplexer (receive side).
package tdm_demux_4ch_pkg;

    // Slots per frame and width of the slot index.
    localparam int NCH    = 4;
    localparam int SLOT_W = 2;

    // Frame alignment states: HUNT searches for frame_sync, RUN is locked.
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : tdm_demux_4ch_pkg

// File: rtl/tdm_demux_4ch_slot_counter.sv
// Two-bit wrapping slot counter; tracks which slot the next accepted sample fills.
module tdm_slot_counter
    import tdm_demux_4ch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load1,
    input  logic              clr,
    output logic [SLOT_W-1:0] sel
);

    logic [SLOT_W-1:0] cnt_q;
    logic [SLOT_W-1:0] cnt_d;

    // Next count: clear wins over load-to-1 (slot 0 just captured), which wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load1) begin
            cnt_d = SLOT_W'(1);
        end else if (inc) begin
            cnt_d = cnt_q + SLOT_W'(1);
        end
    end

    // Counter register; wraps 3 -> 0 through natural 2-bit overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sel = cnt_q;

endmodule : tdm_slot_counter

// File: rtl/tdm_demux_4ch.sv
// Receive-side TDM demultiplexer: rebuilds 4-slot frames from a serial stream,
// tracks frame alignment and flags misplaced or missing frame_sync.
module tdm_demux_4ch
    import tdm_demux_4ch_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [NCH*WIDTH-1:0] channel,
    output logic [SLOT_W-1:0]    sel,
    output logic                 frame_valid,
    output logic                 locked,
    output logic                 sync_err
);

    state_e               state_q, state_d;
    logic [NCH*WIDTH-1:0] channel_q, channel_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 sync_err_q, sync_err_d;
    logic [WIDTH-1:0]     shadow_q [NCH-1];
    logic [WIDTH-1:0]     shadow_d [NCH-1];

    logic                 cnt_inc, cnt_load1, cnt_clr;
    logic                 shadow_wr;
    logic [SLOT_W-1:0]    shadow_idx;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .load1 (cnt_load1),
        .clr   (cnt_clr),
        .sel   (sel)
    );

    // Frame alignment decisions for the sample accepted on this edge.
    always_comb begin
        state_d       = state_q;
        channel_d     = channel_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        cnt_inc       = 1'b0;
        cnt_load1     = 1'b0;
        cnt_clr       = 1'b0;
        shadow_wr     = 1'b0;
        shadow_idx    = '0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    // Unsynced samples are dropped until the first slot-0 marker.
                    if (frame_sync) begin
                        shadow_wr = 1'b1;
                        cnt_load1 = 1'b1;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (frame_sync) begin
                        // Early sync drops the partial frame and restarts at slot 0.
                        shadow_wr  = 1'b1;
                        cnt_load1  = 1'b1;
                        sync_err_d = (sel != '0);
                    end else if (sel == '0) begin
                        // Expected slot 0 came without sync: alignment lost.
                        sync_err_d = 1'b1;
                        cnt_clr    = 1'b1;
                        state_d    = HUNT;
                    end else if (sel == SLOT_W'(NCH - 1)) begin
                        // Last slot completes the frame straight from din.
                        for (int k = 0; k < NCH - 1; k++) begin
                            channel_d[k*WIDTH +: WIDTH] = shadow_q[k];
                        end
                        channel_d[(NCH-1)*WIDTH +: WIDTH] = din;
                        frame_valid_d = 1'b1;
                        cnt_inc       = 1'b1;
                    end else begin
                        shadow_wr  = 1'b1;
                        shadow_idx = sel;
                        cnt_inc    = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // One shadow register per non-final slot; only the addressed one loads.
    generate
        for (genvar gi = 0; gi < NCH - 1; gi++) begin : g_shadow
            always_comb begin
                shadow_d[gi] = shadow_q[gi];
                if (shadow_wr && (shadow_idx == SLOT_W'(gi))) begin
                    shadow_d[gi] = din;
                end
            end
        end
    endgenerate

    // State, shadow and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            channel_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int k = 0; k < NCH - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            channel_q     <= channel_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            for (int k = 0; k < NCH - 1; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign channel     = channel_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == RUN);

endmodule : tdm_demux_4ch

// File: tb/tb_tdm_demux_4ch.sv
// Directed scoreboard bench for tdm_demux_4ch (WIDTH=1).
module tb_tdm_demux_4ch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [3:0] channel;
    logic [1:0] sel;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       is_err;
        logic [3:0] ch;
    } event_t;

    event_t exp_q[$];

    tdm_demux_4ch #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .channel     (channel),
        .sel         (sel),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Drive one accepted sample; the following rising edge consumes it.
    task automatic send(input logic d, input logic fs);
        @(negedge clk);
        din        = d;
        din_valid  = 1'b1;
        frame_sync = fs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid  = 1'b0;
            frame_sync = 1'b0;
        end
    endtask

    task automatic push(input logic is_err, input logic [3:0] ch);
        event_t e;
        e.is_err = is_err;
        e.ch     = ch;
        exp_q.push_back(e);
    endtask

    // Monitor: each pulse observed pops one expected event and is compared to it.
    initial begin
        event_t e;
        forever begin
            @(negedge clk);
            #1;
            if (frame_valid && sync_err) begin
                check("pulse_overlap", 1, 0);
            end else if (frame_valid || sync_err) begin
                if (exp_q.size() == 0) begin
                    check(sync_err ? "unexpected_sync_err" : "unexpected_frame_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.is_err ? "evt_kind_sync_err" : "evt_kind_frame_valid", {31'b0, sync_err}, {31'b0, e.is_err});
                    check("evt_channel", {28'b0, channel}, {28'b0, e.ch});
                    $display("event %s channel=%h", sync_err ? "sync_err" : "frame_valid", channel);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_channel", {28'b0, channel}, 32'h0);
        check("rst_locked", {31'b0, locked}, 32'h0);
        check("rst_sel", {30'b0, sel}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Frame 4'h5 (slot 0 first: 1,0,1,0)
        push(1'b0, 4'h5);
        send(1, 1);
        idle(1);
        check("f1_locked", {31'b0, locked}, 32'h1);
        check("f1_sel", {30'b0, sel}, 32'h1);
        send(0, 0); send(1, 0); send(0, 0);
        idle(3);

        // Frame 4'ha
        push(1'b0, 4'ha);
        send(0, 1); send(1, 0); send(0, 0); send(1, 0);
        idle(3);

        // Frame 4'h5 with a 3-cycle gap between slot 1 and slot 2
        push(1'b0, 4'h5);
        send(1, 1); send(0, 0);
        idle(3);
        check("gap_no_fv", {31'b0, frame_valid}, 32'h0);
        check("gap_channel_hold", {28'b0, channel}, 32'ha);
        send(1, 0); send(0, 0);
        idle(3);

        // Early sync after two samples, then 1,1,1 -> 4'he
        send(1, 1); send(1, 0);
        push(1'b1, 4'h5);
        push(1'b0, 4'he);
        send(0, 1); send(1, 0); send(1, 0); send(1, 0);
        idle(3);
        check("early_locked", {31'b0, locked}, 32'h1);

        // Missing sync on slot 0 drops lock
        push(1'b1, 4'he);
        send(1, 0);
        idle(2);
        check("miss_locked", {31'b0, locked}, 32'h0);
        check("miss_channel", {28'b0, channel}, 32'he);
        push(1'b0, 4'h3);
        send(1, 1); send(1, 0); send(0, 0); send(0, 0);
        idle(3);
        check("relock_locked", {31'b0, locked}, 32'h1);

        // Reset mid-frame after slot 2
        send(1, 1); send(0, 0); send(1, 0);
        @(negedge clk);
        din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_rst_channel", {28'b0, channel}, 32'h0);
        check("amid_rst_locked", {31'b0, locked}, 32'h0);
        check("amid_rst_sel", {30'b0, sel}, 32'h0);
        check("amid_rst_fv", {31'b0, frame_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 0);
        idle(5);
        check("post_rst_channel", {28'b0, channel}, 32'h0);
        check("post_rst_locked", {31'b0, locked}, 32'h0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tdm_demux_4ch
